// File: rtl/regfile_sb.sv
// Multi-port register file: two write ports, NUM_RD read ports, write-to-read bypass, per-register busy scoreboard.
// Latency: reads and bypass are combinational; writes, busy bits and Busy_count update on the rising edge.
// Backpressure: none; every port is served every cycle, and hazards are reported through Rd_ready.
module regfile_sb #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 4,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           W_en0,
  input  logic [ADDR_WIDTH-1:0]          Rd0,
  input  logic [DATA_WIDTH-1:0]          Wr_data0,
  input  logic                           W_en1,
  input  logic [ADDR_WIDTH-1:0]          Rd1,
  input  logic [DATA_WIDTH-1:0]          Wr_data1,
  input  logic                           Alloc_en,
  input  logic [ADDR_WIDTH-1:0]          Alloc_rd,
  input  logic                           Flush,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   Rs,
  output logic [NUM_RD*DATA_WIDTH-1:0]   Rd_data,
  output logic [NUM_RD-1:0]              Rd_ready,
  output logic [ADDR_WIDTH:0]            Busy_count
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [ADDR_WIDTH:0]   busy_count_q, busy_count_d;
  logic                  we0, we1, alloc;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Register 0 is hard-wired to zero only when ZERO_REG is set.
  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Reset masks every state-changing input, which also hides the bypass path while rst is high.
  assign we0   = W_en0 & ~rst & ~is_zero_reg(Rd0);
  assign we1   = W_en1 & ~rst & ~is_zero_reg(Rd1);
  assign alloc = Alloc_en & ~rst & ~is_zero_reg(Alloc_rd);

  // Busy next state: hold, then write clears, then Flush clears all, then Alloc sets (highest wins).
  always_comb begin
    busy_d = busy_q;
    if (we0)   busy_d[Rd0] = 1'b0;
    if (we1)   busy_d[Rd1] = 1'b0;
    if (Flush) busy_d = '0;
    if (alloc) busy_d[Alloc_rd] = 1'b1;
  end

  // Popcount of the post-edge busy vector, so the registered count never lags the bits.
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_count_d = busy_count_d + (ADDR_WIDTH+1)'(busy_d[i]);
    end
  end

  // Read ports: zero register, then port 1 bypass, then port 0 bypass, then the array and scoreboard.
  always_comb begin
    Rd_data  = '0;
    Rd_ready = '0;
    rd_addr  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr = Rs[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (is_zero_reg(rd_addr)) begin
        Rd_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        Rd_ready[k] = 1'b1;
      end else if (we1 && (Rd1 == rd_addr)) begin
        Rd_data[k*DATA_WIDTH +: DATA_WIDTH] = Wr_data1;
        Rd_ready[k] = 1'b1;
      end else if (we0 && (Rd0 == rd_addr)) begin
        Rd_data[k*DATA_WIDTH +: DATA_WIDTH] = Wr_data0;
        Rd_ready[k] = 1'b1;
      end else begin
        Rd_data[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_addr];
        Rd_ready[k] = ~busy_q[rd_addr];
      end
    end
  end

  // State commit; port 1 is written last so it wins a same-register conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      if (we0) regs_q[Rd0] <= Wr_data0;
      if (we1) regs_q[Rd1] <= Wr_data1;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign Busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with default parameters (64-bit, 32 regs, 4 read ports, zero register on).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later, well before the next edge.
// Expected values are hand-derived constants.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        W_en0, W_en1, Alloc_en, Flush;
  logic [4:0]  Rd0, Rd1, Alloc_rd;
  logic [63:0] Wr_data0, Wr_data1;
  logic [19:0] Rs;
  logic [255:0] Rd_data;
  logic [3:0]  Rd_ready;
  logic [5:0]  Busy_count;

  int errors = 0;
  int checks = 0;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .W_en0(W_en0), .Rd0(Rd0), .Wr_data0(Wr_data0),
    .W_en1(W_en1), .Rd1(Rd1), .Wr_data1(Wr_data1),
    .Alloc_en(Alloc_en), .Alloc_rd(Alloc_rd), .Flush(Flush),
    .Rs(Rs), .Rd_data(Rd_data), .Rd_ready(Rd_ready), .Busy_count(Busy_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] rdp(input int k);
    return Rd_data[k*64 +: 64];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    W_en0 = 0; W_en1 = 0; Alloc_en = 0; Flush = 0;
    Rd0 = 0; Rd1 = 0; Alloc_rd = 0; Wr_data0 = 0; Wr_data1 = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    Rs = {5'd3, 5'd2, 5'd1, 5'd0};

    // Reset held for two edges.
    tick();
    #1;
    chk("rst_hold_data1", rdp(1), 64'h0);
    chk("rst_hold_ready", {60'h0, Rd_ready}, 64'hF);
    tick();
    rst = 0;
    #1;
    chk("reset_data0", rdp(0), 64'h0);
    chk("reset_data1", rdp(1), 64'h0);
    chk("reset_data2", rdp(2), 64'h0);
    chk("reset_data3", rdp(3), 64'h0);
    chk("reset_ready", {60'h0, Rd_ready}, 64'hF);
    chk("reset_count", {58'h0, Busy_count}, 64'h0);

    // Dual write to r5: port 1 wins, both bypass and array.
    W_en0 = 1; Rd0 = 5; Wr_data0 = 64'hAAAA;
    W_en1 = 1; Rd1 = 5; Wr_data1 = 64'hBBBB;
    Rs = {5'd5, 5'd5, 5'd5, 5'd5};
    #1;
    chk("dual_bypass_p0", rdp(0), 64'hBBBB);
    chk("dual_bypass_p3", rdp(3), 64'hBBBB);
    chk("dual_bypass_rdy", {60'h0, Rd_ready}, 64'hF);
    tick();
    idle();
    #1;
    chk("dual_array", rdp(0), 64'hBBBB);

    // Scoreboard round trip on r7.
    Rs = {5'd0, 5'd0, 5'd0, 5'd7};
    Alloc_en = 1; Alloc_rd = 7;
    #1;
    chk("alloc_same_cycle_rdy", {63'h0, Rd_ready[0]}, 64'h1);
    tick();
    idle();
    #1;
    chk("alloc_next_rdy", {63'h0, Rd_ready[0]}, 64'h0);
    chk("alloc_next_count", {58'h0, Busy_count}, 64'h1);
    W_en0 = 1; Rd0 = 7; Wr_data0 = 64'h1234;
    #1;
    chk("wb_bypass_data", rdp(0), 64'h1234);
    chk("wb_bypass_rdy", {63'h0, Rd_ready[0]}, 64'h1);
    tick();
    idle();
    #1;
    chk("wb_after_data", rdp(0), 64'h1234);
    chk("wb_after_rdy", {63'h0, Rd_ready[0]}, 64'h1);
    chk("wb_after_count", {58'h0, Busy_count}, 64'h0);

    // Zero register ignores writes and allocs.
    Rs = {5'd0, 5'd0, 5'd0, 5'd0};
    W_en0 = 1; Rd0 = 0; Wr_data0 = 64'hFFFF;
    Alloc_en = 1; Alloc_rd = 0;
    #1;
    chk("zero_same_data", rdp(0), 64'h0);
    chk("zero_same_rdy", {63'h0, Rd_ready[0]}, 64'h1);
    tick();
    idle();
    #1;
    chk("zero_next_data", rdp(0), 64'h0);
    chk("zero_next_rdy", {63'h0, Rd_ready[0]}, 64'h1);
    chk("zero_next_count", {58'h0, Busy_count}, 64'h0);

    // Flush versus Alloc: seed r1..r3 with data, mark all busy.
    W_en0 = 1; Rd0 = 1; Wr_data0 = 64'h11;
    W_en1 = 1; Rd1 = 2; Wr_data1 = 64'h22;
    tick();
    idle();
    W_en0 = 1; Rd0 = 3; Wr_data0 = 64'h33;
    tick();
    idle();
    for (int r = 1; r <= 3; r++) begin
      Alloc_en = 1; Alloc_rd = 5'(r);
      tick();
    end
    idle();
    Rs = {5'd3, 5'd2, 5'd1, 5'd0};
    #1;
    chk("busy3_count", {58'h0, Busy_count}, 64'h3);
    chk("busy3_ready", {60'h0, Rd_ready}, 64'h1);
    Flush = 1; Alloc_en = 1; Alloc_rd = 2;
    tick();
    idle();
    #1;
    chk("flush_ready", {60'h0, Rd_ready}, 64'hB);
    chk("flush_count", {58'h0, Busy_count}, 64'h1);
    chk("flush_r1", rdp(1), 64'h11);
    chk("flush_r2", rdp(2), 64'h22);
    chk("flush_r3", rdp(3), 64'h33);

    // Alloc plus write to the same busy register keeps it busy.
    Alloc_en = 1; Alloc_rd = 9;
    tick();
    idle();
    Rs = {5'd0, 5'd0, 5'd0, 5'd9};
    #1;
    chk("r9_busy_count", {58'h0, Busy_count}, 64'h2);
    W_en1 = 1; Rd1 = 9; Wr_data1 = 64'h9999;
    Alloc_en = 1; Alloc_rd = 9;
    #1;
    chk("r9_bypass", rdp(0), 64'h9999);
    tick();
    idle();
    #1;
    chk("r9_data", rdp(0), 64'h9999);
    chk("r9_still_busy", {63'h0, Rd_ready[0]}, 64'h0);
    chk("r9_count", {58'h0, Busy_count}, 64'h2);

    // Mid-operation reset with r4 busy and a write pending.
    Alloc_en = 1; Alloc_rd = 4;
    tick();
    idle();
    Rs = {5'd9, 5'd5, 5'd2, 5'd4};
    #1;
    chk("r4_busy_count", {58'h0, Busy_count}, 64'h3);
    rst = 1;
    W_en0 = 1; Rd0 = 4; Wr_data0 = 64'h4444;
    Alloc_en = 1; Alloc_rd = 6; Flush = 1;
    tick();
    #1;
    chk("mid_rst_bypass_off", rdp(0), 64'h0);
    chk("mid_rst_ready", {60'h0, Rd_ready}, 64'hF);
    chk("mid_rst_count", {58'h0, Busy_count}, 64'h0);
    tick();
    rst = 0;
    idle();
    #1;
    chk("post_rst_r4", rdp(0), 64'h0);
    chk("post_rst_r2", rdp(1), 64'h0);
    chk("post_rst_r5", rdp(2), 64'h0);
    chk("post_rst_r9", rdp(3), 64'h0);
    chk("post_rst_ready", {60'h0, Rd_ready}, 64'hF);
    chk("post_rst_count", {58'h0, Busy_count}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard. It replaces the single-write, two-read register file in the pipelined core's decode/writeback path. Two writeback ports and N read ports can be served per cycle. The scoreboard tracks registers that have an in-flight producer so that decode can detect RAW hazards without a separate structure.

## Interface
Parameters:
- DATA_WIDTH, 64, register width in bits
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH
- NUM_RD, 4, number of read ports, minimum 1
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- W_en0  in  1  write port 0 enable
- Rd0  in  ADDR_WIDTH  write port 0 destination
- Wr_data0  in  DATA_WIDTH  write port 0 data
- W_en1  in  1  write port 1 enable; has priority over port 0
- Rd1  in  ADDR_WIDTH  write port 1 destination
- Wr_data1  in  DATA_WIDTH  write port 1 data
- Alloc_en  in  1  mark register Alloc_rd busy, issued with a new producer
- Alloc_rd  in  ADDR_WIDTH  register to mark busy
- Flush  in  1  clear all busy bits; register data is retained
- Rs  in  NUM_RD*ADDR_WIDTH  read addresses; port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH]
- Rd_data  out  NUM_RD*DATA_WIDTH  read data, packed the same way as Rs
- Rd_ready  out  NUM_RD  1 = the value returned on port k is final (not busy, or bypassed this cycle)
- Busy_count  out  ADDR_WIDTH+1  registered count of currently busy registers

## Operation
- Storage: NUM_REGS x DATA_WIDTH array and a NUM_REGS-bit busy vector.
- Write commit, on the rising edge:
  - When W_enX=1 and the destination is not zero-protected, regs[RdX] <= Wr_dataX.
  - When both ports target the same register, port 1 data is stored.
  - A write also clears busy[RdX].
- Alloc: when Alloc_en=1 and Alloc_rd is not zero-protected, busy[Alloc_rd] <= 1.
- Busy update priority, lowest to highest:
  - hold
  - clear by committing write
  - clear all by Flush
  - set by Alloc

  Consequently, Alloc plus write (or plus Flush) to the same register in one cycle leaves it busy.
- Reads are combinational, per port k with address a:
  - If ZERO_REG and a==0: data 0, ready 1.
  - Else if W_en1 and Rd1==a: data Wr_data1, ready 1.
  - Else if W_en0 and Rd0==a: data Wr_data0, ready 1.
  - Else: data regs[a], ready ~busy[a].
  - Alloc in the same cycle does not affect that cycle's Rd_ready; it takes effect the next cycle.
- Busy_count: registered, equals popcount of the busy vector after the current edge's update. Range 0..NUM_REGS (0..NUM_REGS-1 when ZERO_REG=1).
- Writes to a register that is not busy are legal: data is updated and busy stays 0.

## Timing
- Reset (rst=1 at a rising edge):
  - All registers become 0, all busy bits 0, Busy_count 0.
  - While rst=1, Rd_data reads 0 after the first edge and Rd_ready reads 1.
  - Write, Alloc and Flush inputs are ignored while rst=1, including mid-operation; reset overrides all.
- Write-to-read latency: 0 cycles via bypass, and the array holds the value from the next cycle onward.
- Alloc-to-busy latency: 1 cycle. Rd_ready for that register drops in the cycle after Alloc_en.
- Busy_count lags the busy vector by 0 cycles; both are updated on the same edge.
- No read-port conflicts: all NUM_RD ports are independent, and the same address on multiple ports returns identical results.
- Register 0 with ZERO_REG=0: behaves as an ordinary register.

## Test plan
- Reset then read: rst=1 for 2 cycles, release, read Rs={3,2,1,0} -> all Rd_data=0, Rd_ready=4'b1111, Busy_count=0.
- Dual write with conflict: W_en0=1 Rd0=5 data 0xAAAA, W_en1=1 Rd1=5 data 0xBBBB.
  - Same cycle: port reading 5 returns 0xBBBB with ready 1.
  - Next cycle with no writes: 0xBBBB.
- Scoreboard round trip:
  - Alloc r7 -> next cycle Rd_ready for r7 = 0 and Busy_count=1.
  - Write r7=0x1234 on port 0 -> same cycle data 0x1234, ready 1.
  - Next cycle: busy 0, Busy_count=0.
- Zero register: W_en0=1 Rd0=0 data 0xFFFF plus Alloc r0 -> read r0 gives 0, ready 1, Busy_count unchanged.
- Flush versus Alloc: mark r1,r2,r3 busy (Busy_count=3), then Flush=1 with Alloc r2 in the same cycle -> next cycle only r2 busy, Busy_count=1, data of r1..r3 unchanged.
- Alloc with write to the same register: r9 busy, W_en1=1 Rd1=9 and Alloc r9 in the same cycle -> r9 holds the new data, remains busy, Busy_count unchanged.
- Mid-operation reset: while r4 is busy and a write is pending, assert rst -> next cycle all data 0, busy 0, Busy_count 0.
